// File: rtl/mc_datapath.sv
// Multicycle datapath: PC, 8-entry register file, ALU and control FSM sharing
// one request/ready memory port for instruction fetch and data access.
module mc_datapath #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [PC_W-1:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic [CNT_W-1:0]  retired,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    typedef enum logic [2:0] {
        S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
        OP_SLT  = 4'd4, OP_ADDI = 4'd5, OP_LW = 4'd6, OP_SW = 4'd7,
        OP_BEQ  = 4'd8, OP_J = 4'd9, OP_HALT = 4'd15
    } opcode_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
    logic [DATA_W-1:0]   alu_q, alu_d, mdr_q, mdr_d;
    logic [DATA_W-1:0]   regs_q [8];
    logic [DATA_W-1:0]   regs_d [8];
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                halted_q, halted_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [PC_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [3:0]          op;
    logic [2:0]          ra, rb, rc;
    logic [DATA_W-1:0]   imm_ext, ea;
    logic [PC_W-1:0]     br_target;
    logic                enter_fetch, retire;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        alu_d       = alu_q;
        mdr_d       = mdr_q;
        regs_d      = regs_q;
        retired_d   = retired_q;
        halted_d    = halted_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        enter_fetch = 1'b0;
        retire      = 1'b0;

        op        = ir_q[15:12];
        ra        = ir_q[11:9];
        rb        = ir_q[8:6];
        rc        = ir_q[5:3];
        imm_ext   = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
        ea        = a_q + imm_ext;
        // pc_q already holds the fetched address + 2 by EXEC
        br_target = pc_q + {imm_ext[PC_W-2:0], 1'b0};

        case (state_q)
            S_START: enter_fetch = 1'b1;
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d      = mem_rdata[15:0];
                    pc_d      = pc_q + PC_W'(2);
                    mem_req_d = 1'b0;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = (op == OP_BEQ) ? regs_q[ra] : regs_q[rb];
                b_d     = (op == OP_BEQ) ? regs_q[rb] : regs_q[rc];
                s_d     = regs_q[ra];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD:  begin alu_d = a_q + b_q; state_d = S_WB; end
                    OP_SUB:  begin alu_d = a_q - b_q; state_d = S_WB; end
                    OP_AND:  begin alu_d = a_q & b_q; state_d = S_WB; end
                    OP_OR:   begin alu_d = a_q | b_q; state_d = S_WB; end
                    OP_SLT: begin
                        alu_d   = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                        state_d = S_WB;
                    end
                    OP_ADDI: begin alu_d = ea; state_d = S_WB; end
                    OP_LW, OP_SW: begin
                        alu_d       = ea;
                        state_d     = S_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (op == OP_SW);
                        mem_addr_d  = ea[PC_W-1:0];
                        mem_wdata_d = s_q;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) pc_d = br_target;
                        retire      = 1'b1;
                        enter_fetch = 1'b1;
                    end
                    OP_J: begin
                        pc_d        = {ir_q[PC_W-2:0], 1'b0};
                        retire      = 1'b1;
                        enter_fetch = 1'b1;
                    end
                    OP_HALT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    default: begin
                        retire      = 1'b1;
                        enter_fetch = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (op == OP_LW) begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end else begin
                        retire      = 1'b1;
                        enter_fetch = 1'b1;
                    end
                end
            end
            S_WB: begin
                regs_d[ra]  = (op == OP_LW) ? mdr_q : alu_q;
                retire      = 1'b1;
                enter_fetch = 1'b1;
            end
            S_HALT: ;
            default: state_d = S_START;
        endcase

        if (enter_fetch) begin
            state_d    = S_FETCH;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_d;
        end
        if (retire) retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_START;
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            regs_q      <= '{default: '0};
            retired_q   <= '0;
            halted_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            regs_q      <= regs_d;
            retired_q   <= retired_d;
            halted_q    <= halted_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign retired   = retired_q;
    assign dbg_data  = regs_q[dbg_sel];
endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: directed programs plus a random program checked
// against an instruction-level reference model, with a wait-state memory.
module tb_mc_datapath;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PC_W   = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned N_RET  = 150;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, halted;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_wdata, retired, dbg_data;
    logic [15:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [2:0]  dbg_sel = '0;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic [15:0] rf [8];
    logic [7:0]  ref_pc;
    int unsigned ref_cnt;
    int unsigned n_checks = 0, n_errs = 0;
    int unsigned wcnt = 0, cur_wait = 0, waits = 0;
    int unsigned we_cycles = 0, req_cycles = 0, bad = 0;
    bit          rand_waits = 1'b0, xfer = 1'b0;
    logic [7:0]  h_addr = '0, we_addr = '0;
    logic        h_we = 1'b0;
    logic [15:0] h_wdata = '0, w;
    logic [2:0]  last_ra;

    always #5 clk = ~clk;

    mc_datapath #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .halted(halted), .retired(retired),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int ra, input int rb, input int lo);
        return {4'(op), 3'(ra), 3'(rb), 6'(lo)};
    endfunction

    // One clock: memory responds at the negedge, writes commit after the edge.
    task automatic tick();
        @(negedge clk);
        xfer = 1'b0;
        if (mem_req === 1'b1) begin
            req_cycles++;
            if (mem_we === 1'b1) begin
                we_cycles++;
                we_addr = mem_addr;
            end
            if (wcnt == 0) begin
                h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
                cur_wait = rand_waits ? $urandom_range(0, 2) : waits;
            end else begin
                check("stall_addr", 32'(mem_addr), 32'(h_addr));
                check("stall_we", 32'(mem_we), 32'(h_we));
                check("stall_wdata", 32'(mem_wdata), 32'(h_wdata));
            end
            if (wcnt >= cur_wait) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr];
                xfer = 1'b1;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
            end
            wcnt++;
        end else begin
            mem_ready = 1'($urandom);
            mem_rdata = 16'($urandom);
            wcnt = 0;
        end
        @(posedge clk);
        if (xfer && reset === 1'b1) begin
            if (h_we) mem[h_addr] = h_wdata;
            wcnt = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        wcnt = 0;
        tick();
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_retired", 32'(retired), 32'h0);
        for (int r = 0; r < 8; r++) begin
            dbg_sel = 3'(r);
            #1;
            check("rst_reg", 32'(dbg_data), 32'h0);
        end
        tick();
        tick();
        reset = 1'b1;
        check("c0_req", 32'(mem_req), 32'h0);
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic read_reg(input int r, input string tag, input logic [15:0] exp);
        dbg_sel = 3'(r);
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    // Instruction-level reference: executes one whole instruction.
    task automatic iss_step(output logic [2:0] dst);
        logic [15:0] in, imm, ea;
        logic [2:0]  ra, rb, rc;
        in  = ref_mem[ref_pc];
        ref_pc = ref_pc + 8'd2;
        ra = in[11:9]; rb = in[8:6]; rc = in[5:3];
        imm = {{10{in[5]}}, in[5:0]};
        ea  = rf[rb] + imm;
        case (in[15:12])
            4'd0: rf[ra] = rf[rb] + rf[rc];
            4'd1: rf[ra] = rf[rb] - rf[rc];
            4'd2: rf[ra] = rf[rb] & rf[rc];
            4'd3: rf[ra] = rf[rb] | rf[rc];
            4'd4: rf[ra] = ($signed(rf[rb]) < $signed(rf[rc])) ? 16'd1 : 16'd0;
            4'd5: rf[ra] = ea;
            4'd6: rf[ra] = ref_mem[ea[7:0]];
            4'd7: ref_mem[ea[7:0]] = rf[ra];
            4'd8: if (rf[ra] == rf[rb]) ref_pc = ref_pc + {imm[6:0], 1'b0};
            4'd9: ref_pc = {in[6:0], 1'b0};
            default: ;
        endcase
        ref_cnt++;
        dst = ra;
    endtask

    initial begin
        #2;
        // Reset sequencing and first fetch
        fill_mem(16'hF000);
        mem[0] = 16'hA000;
        do_reset();
        tick();
        check("c1_req", 32'(mem_req), 32'h1);
        check("c1_addr", 32'(mem_addr), 32'h0);
        check("c1_pc", 32'(pc), 32'h0);
        tick();
        check("fetch_pc", 32'(pc), 32'h2);
        check("fetch_req_drop", 32'(mem_req), 32'h0);

        // Arithmetic program, zero-wait
        fill_mem(16'hF000);
        mem[0] = enc(5, 1, 0, 5);
        mem[2] = enc(5, 2, 0, -3);
        mem[4] = enc(0, 3, 1, 2 << 3);
        mem[6] = enc(1, 4, 2, 1 << 3);
        mem[8] = enc(4, 5, 2, 1 << 3);
        do_reset();
        repeat (20) tick();
        check("arith_ret20", 32'(retired), 32'd4);
        tick();
        check("arith_ret21", 32'(retired), 32'd5);
        read_reg(3, "arith_r3", 16'h0002);
        read_reg(4, "arith_r4", 16'hFFF8);
        read_reg(5, "arith_r5", 16'h0001);

        // Load/store with two wait cycles on every request
        fill_mem(16'hF000);
        mem[0]    = 16'h9008;
        mem[8'h10] = enc(5, 1, 0, -7);
        mem[8'h12] = enc(7, 1, 0, 6);
        mem[8'h14] = enc(6, 6, 0, 6);
        waits = 2;
        do_reset();
        we_cycles = 0;
        repeat (60) tick();
        check("ls_we_cycles", we_cycles, 32'd3);
        check("ls_we_addr", 32'(we_addr), 32'h06);
        check("ls_mem6", 32'(mem[6]), 32'hFFF9);
        read_reg(6, "ls_r6", 16'hFFF9);
        check("ls_retired", 32'(retired), 32'd4);
        check("ls_halted", 32'(halted), 32'h1);
        waits = 0;

        // BEQ to itself: retires every 3 cycles, pc stays put
        fill_mem(16'hF000);
        mem[0] = 16'h803F;
        do_reset();
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            tick();
            check("beq_ret_before", 32'(retired), 32'(k - 1));
            tick();
            check("beq_ret", 32'(retired), 32'(k));
            check("beq_pc", 32'(pc), 32'h0);
            check("beq_addr", 32'(mem_addr), 32'h0);
        end

        // J 0x25 -> next fetch at 0x4A
        fill_mem(16'hF000);
        mem[0] = 16'h9025;
        do_reset();
        repeat (4) tick();
        check("j_pc", 32'(pc), 32'h4A);
        check("j_req", 32'(mem_req), 32'h1);
        check("j_addr", 32'(mem_addr), 32'h4A);
        check("j_ret", 32'(retired), 32'd1);

        // Fetch at the top of the address space wraps pc to 0
        fill_mem(16'hF000);
        mem[0] = 16'h907F;
        mem[8'hFE] = 16'hA000;
        do_reset();
        repeat (4) tick();
        check("wrap_j_pc", 32'(pc), 32'hFE);
        tick();
        check("wrap_fetch_pc", 32'(pc), 32'h00);

        // Taken branch with target below zero wraps
        mem[0] = 16'h803E;
        do_reset();
        repeat (4) tick();
        check("wrap_beq_pc", 32'(pc), 32'hFE);
        check("wrap_beq_addr", 32'(mem_addr), 32'hFE);

        // HALT after two NOPs
        fill_mem(16'hF000);
        mem[0] = 16'hA000;
        mem[2] = 16'hA000;
        do_reset();
        repeat (9) tick();
        check("halt_early", 32'(halted), 32'h0);
        tick();
        check("halt_set", 32'(halted), 32'h1);
        req_cycles = 0;
        repeat (20) tick();
        check("halt_req_idle", req_cycles, 32'd0);
        check("halt_held", 32'(halted), 32'h1);
        check("halt_retired", 32'(retired), 32'd2);

        // Asynchronous reset during a stalled LW
        fill_mem(16'hF000);
        mem[0]  = enc(6, 6, 0, 30);
        mem[30] = 16'hBEEF;
        waits = 3;
        do_reset();
        repeat (8) tick();
        check("ar_in_mem_req", 32'(mem_req), 32'h1);
        check("ar_in_mem_addr", 32'(mem_addr), 32'd30);
        reset = 1'b0;
        #1;
        check("ar_req_drop", 32'(mem_req), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        check("ar_pc", 32'(pc), 32'h0);
        check("ar_retired", 32'(retired), 32'h0);
        read_reg(6, "ar_r6", 16'h0000);
        waits = 0;
        repeat (10) tick();
        read_reg(6, "ar_restart_r6", 16'hBEEF);
        check("ar_restart_ret", 32'(retired), 32'd1);
        check("ar_restart_halt", 32'(halted), 32'h1);

        // Random program with random wait states against the reference model
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'h5;
            mem[i] = w;
        end
        rand_waits = 1'b1;
        do_reset();
        ref_mem = mem;
        for (int r = 0; r < 8; r++) rf[r] = '0;
        ref_pc = '0;
        ref_cnt = 0;
        for (int c = 0; c < 3000 && ref_cnt < N_RET; c++) begin
            tick();
            if (retired !== 16'(ref_cnt)) begin
                iss_step(last_ra);
                dbg_sel = last_ra;
                #1;
                check("rand_retired", 32'(retired), ref_cnt);
                check("rand_pc", 32'(pc), 32'(ref_pc));
                check("rand_reg", 32'(dbg_data), 32'(rf[last_ra]));
            end
        end
        if (ref_cnt < N_RET)
            check("rand_stopped_at_halt", {30'd0, halted, ref_mem[ref_pc][15:12] == 4'hF}, 32'h3);
        else
            check("rand_not_halted", 32'(halted), 32'h0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("rand_mem_image", bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
